// File: rtl/sync_pkg.sv
// Shared types and default timing constants for the camera sync lock controller.
// Defaults describe a 1280x720 stream.
package sync_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_LOST
  } state_e;

  localparam int unsigned H_ACT_DEF       = 1280;
  localparam int unsigned V_ACT_DEF       = 720;
  localparam int unsigned LOCK_FRAMES_DEF = 3;
  localparam int unsigned TIMEOUT_DEF     = 2000000;

endpackage

// File: rtl/edge_det.sv
// Registers one synchronous input and flags its rising and falling edges
// by comparing the live value with the registered copy.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) d_q <= 1'b0;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/sync_lock_ctrl.sv
// Measures camera line/frame geometry and locks after enough clean frames;
// releases the downstream sync generator reset only while locked.
module sync_lock_ctrl
  import sync_pkg::*;
#(
  parameter int unsigned H_ACT       = H_ACT_DEF,
  parameter int unsigned V_ACT       = V_ACT_DEF,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        cam_href,
  input  logic                        cam_vsync,
  output logic                        locked,
  output logic                        gen_rstn,
  output logic                        lock_err,
  output logic [$clog2(H_ACT+2)-1:0]  line_len,
  output logic [$clog2(V_ACT+2)-1:0]  frame_lines
);

  localparam int AW = $clog2(H_ACT + 2);
  localparam int LW = $clog2(V_ACT + 2);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam int GW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;

  localparam logic [AW-1:0] ACT_EXP   = AW'(H_ACT);
  localparam logic [AW-1:0] ACT_MAX   = AW'(H_ACT + 1);
  localparam logic [LW-1:0] LINE_EXP  = LW'(V_ACT);
  localparam logic [LW-1:0] LINE_MAX  = LW'(V_ACT + 1);
  localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_MAX    = TW'(TIMEOUT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_FRAMES - 1);

  logic href_fall, vsync_rise;
  logic unused_href_rise, unused_vsync_fall;

  edge_det u_href (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (cam_href),
    .rise_o (unused_href_rise),
    .fall_o (href_fall)
  );

  edge_det u_vsync (
    .clk    (clk),
    .rstn   (rstn),
    .d_i    (cam_vsync),
    .rise_o (vsync_rise),
    .fall_o (unused_vsync_fall)
  );

  state_e        state_q, state_d;
  logic [GW-1:0] good_q, good_d;
  logic [AW-1:0] act_q, act_d;
  logic [LW-1:0] line_q, line_d;
  logic [TW-1:0] to_q, to_d;
  logic          bad_q, bad_d;
  logic [AW-1:0] ll_q, ll_d;
  logic [LW-1:0] fl_q, fl_d;
  logic          gen_q;

  logic [LW-1:0] line_inc, lines_eff;
  logic          bad_eff, frame_good, timeout;

  // A line closing on the same cycle as vsync still belongs to that frame.
  always_comb begin
    line_inc   = (line_q == LINE_MAX) ? line_q : line_q + LW'(1);
    lines_eff  = href_fall ? line_inc : line_q;
    bad_eff    = bad_q | (href_fall & (act_q != ACT_EXP));
    frame_good = (lines_eff == LINE_EXP) & ~bad_eff;
    timeout    = (to_q >= TO_LIM);
  end

  always_comb begin
    act_d  = act_q;
    line_d = line_q;
    bad_d  = bad_q;
    ll_d   = ll_q;
    fl_d   = fl_q;
    to_d   = to_q;

    if (href_fall) begin
      act_d  = '0;
      ll_d   = act_q;
      line_d = line_inc;
      bad_d  = bad_eff;
    end else if (cam_href && act_q != ACT_MAX) begin
      act_d = act_q + AW'(1);
    end

    if (vsync_rise) begin
      fl_d   = lines_eff;
      line_d = '0;
      bad_d  = 1'b0;
    end

    if (vsync_rise || state_q == ST_IDLE) to_d = '0;
    else if (to_q != TO_MAX)              to_d = to_q + TW'(1);

    if (state_q == ST_LOST) begin
      act_d  = '0;
      line_d = '0;
      bad_d  = 1'b0;
      to_d   = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    unique case (state_q)
      ST_IDLE: begin
        if (vsync_rise) begin
          state_d = ST_ACQUIRE;
          good_d  = '0;
        end
      end
      ST_ACQUIRE: begin
        if (timeout) begin
          state_d = ST_LOST;
        end else if (vsync_rise) begin
          if (!frame_good) begin
            good_d = '0;
          end else if (good_q == GOOD_LAST) begin
            state_d = ST_LOCKED;
            good_d  = '0;
          end else begin
            good_d = good_q + GW'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (timeout || (vsync_rise && !frame_good))
          state_d = ST_LOST;
      end
      ST_LOST: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      good_q  <= '0;
      gen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      gen_q   <= (state_q == ST_LOCKED);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q  <= '0;
      line_q <= '0;
      bad_q  <= 1'b0;
      ll_q   <= '0;
      fl_q   <= '0;
      to_q   <= '0;
    end else begin
      act_q  <= act_d;
      line_q <= line_d;
      bad_q  <= bad_d;
      ll_q   <= ll_d;
      fl_q   <= fl_d;
      to_q   <= to_d;
    end
  end

  assign locked      = (state_q == ST_LOCKED);
  assign lock_err    = (state_q == ST_LOST);
  assign gen_rstn    = gen_q;
  assign line_len    = ll_q;
  assign frame_lines = fl_q;

endmodule
